// File: rtl/huffman_decoder.sv
// -----------------------------------------------------------------------------
// huffman_decoder
//
// Serial Huffman bitstream decoder. One code bit is accepted per cycle and
// shifted into a prefix accumulator; the prefix is matched against a 16-entry
// code table that is loaded at run time. A match presents the table index as a
// 4-bit symbol on a valid/ready output. A prefix that reaches MAX_LEN bits
// without matching is discarded and reported with a one-cycle ERR pulse.
//
// Parameters
//   MAX_LEN   maximum code length in bits (1..8), width of the accumulator
//   CNT_W     width of the decoded-symbol counter
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous, active-high reset
//   TBL_WE     table write strobe (also flushes a partial prefix)
//   TBL_ADDR   symbol index being written
//   TBL_LEN    code length; 0 = unused, lengths above MAX_LEN stored as 0
//   TBL_CODE   code bits, right-aligned, first transmitted bit is the MSB
//   BIT_IN     code bit
//   BIT_VALID  BIT_IN is valid
//   BIT_READY  decoder accepts a bit this cycle (combinational)
//   SYM_OUT    decoded symbol
//   SYM_VALID  SYM_OUT holds an unconsumed symbol
//   SYM_READY  downstream consumes SYM_OUT
//   ERR        one-cycle pulse: no match after MAX_LEN bits
//   SYM_COUNT  symbols decoded since reset, saturating
//   ERR_COUNT  errors since reset, saturating
// -----------------------------------------------------------------------------
module huffman_decoder #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               TBL_WE,
    input  logic [3:0]         TBL_ADDR,
    input  logic [3:0]         TBL_LEN,
    input  logic [MAX_LEN-1:0] TBL_CODE,
    input  logic               BIT_IN,
    input  logic               BIT_VALID,
    output logic               BIT_READY,
    output logic [3:0]         SYM_OUT,
    output logic               SYM_VALID,
    input  logic               SYM_READY,
    output logic               ERR,
    output logic [CNT_W-1:0]   SYM_COUNT,
    output logic [7:0]         ERR_COUNT
);

    localparam logic [3:0] MAX_L = 4'(MAX_LEN);

    // Code table
    logic [3:0]         len_tbl  [16];
    logic [MAX_LEN-1:0] code_tbl [16];

    // Prefix accumulator: holds the n bits received so far, right-aligned
    logic [MAX_LEN-1:0] acc;
    logic [3:0]         n;

    // Candidate prefix for the bit offered this cycle
    logic               accept;
    logic [MAX_LEN-1:0] cand;
    logic [3:0]         cand_len;
    logic [MAX_LEN-1:0] mask;
    logic               hit;
    logic [3:0]         hit_idx;
    logic               last_bit;

    // A held symbol or a table write blocks the input, so a decode can never
    // collide with an unconsumed symbol or with a table update.
    assign BIT_READY = ~SYM_VALID & ~TBL_WE;
    assign accept    = BIT_VALID & BIT_READY;

    assign cand      = (acc << 1) | MAX_LEN'(BIT_IN);
    assign cand_len  = n + 4'd1;
    // Selects the low cand_len bits; a shift by MAX_LEN leaves all ones.
    assign mask      = ~({MAX_LEN{1'b1}} << cand_len);
    assign last_bit  = (cand_len == MAX_L);

    // Parallel match against all entries. Scanning from the top down lets the
    // lowest matching index overwrite any higher one.
    always_comb begin
        // NOTE: every always_comb output gets a default before any condition,
        // otherwise the unassigned paths infer latches.
        hit     = 1'b0;
        hit_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if ((len_tbl[i] == cand_len) && (((code_tbl[i] ^ cand) & mask) == '0)) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register sees pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the table is cleared on reset on purpose: an empty table
            // is the defined post-reset state, so it is built from flops, not
            // an uninitialised RAM.
            for (int i = 0; i < 16; i++) begin
                len_tbl[i]  <= '0;
                code_tbl[i] <= '0;
            end
            acc       <= '0;
            n         <= '0;
            SYM_OUT   <= '0;
            SYM_VALID <= 1'b0;
            ERR       <= 1'b0;
            SYM_COUNT <= '0;
            ERR_COUNT <= '0;
        end else begin
            ERR <= 1'b0;

            if (SYM_VALID && SYM_READY) begin
                SYM_VALID <= 1'b0;
            end

            if (TBL_WE) begin
                // Out-of-range lengths are stored as unused entries.
                len_tbl[TBL_ADDR]  <= (TBL_LEN > MAX_L) ? 4'd0 : TBL_LEN;
                code_tbl[TBL_ADDR] <= TBL_CODE;
                // A partial prefix may be meaningless under the new table.
                acc <= '0;
                n   <= '0;
            end else if (accept) begin
                if (hit) begin
                    SYM_OUT   <= hit_idx;
                    SYM_VALID <= 1'b1;
                    acc       <= '0;
                    n         <= '0;
                    if (SYM_COUNT != '1) begin
                        SYM_COUNT <= SYM_COUNT + CNT_W'(1);
                    end
                end else if (last_bit) begin
                    ERR <= 1'b1;
                    acc <= '0;
                    n   <= '0;
                    if (ERR_COUNT != 8'hFF) begin
                        ERR_COUNT <= ERR_COUNT + 8'd1;
                    end
                end else begin
                    acc <= cand & mask;
                    n   <= cand_len;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// -----------------------------------------------------------------------------
// tb_huffman_decoder
//
// Self-checking bench for huffman_decoder. Inputs change 1 time unit after the
// rising edge; outputs are checked at that point or on the falling edge. A
// scoreboard queue holds the symbols expected in order; a monitor pops and
// compares them whenever the output handshake is seen.
// -----------------------------------------------------------------------------
module tb_huffman_decoder;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 16;

    logic               CLK = 1'b0;
    logic               RST;
    logic               TBL_WE;
    logic [3:0]         TBL_ADDR;
    logic [3:0]         TBL_LEN;
    logic [MAX_LEN-1:0] TBL_CODE;
    logic               BIT_IN;
    logic               BIT_VALID;
    logic               BIT_READY;
    logic [3:0]         SYM_OUT;
    logic               SYM_VALID;
    logic               SYM_READY;
    logic               ERR;
    logic [CNT_W-1:0]   SYM_COUNT;
    logic [7:0]         ERR_COUNT;

    int n_checks = 0;
    int n_fails  = 0;
    int err_seen = 0;
    logic [3:0] sb[$];

    huffman_decoder #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .TBL_WE    (TBL_WE),
        .TBL_ADDR  (TBL_ADDR),
        .TBL_LEN   (TBL_LEN),
        .TBL_CODE  (TBL_CODE),
        .BIT_IN    (BIT_IN),
        .BIT_VALID (BIT_VALID),
        .BIT_READY (BIT_READY),
        .SYM_OUT   (SYM_OUT),
        .SYM_VALID (SYM_VALID),
        .SYM_READY (SYM_READY),
        .ERR       (ERR),
        .SYM_COUNT (SYM_COUNT),
        .ERR_COUNT (ERR_COUNT)
    );

    always #5 CLK = ~CLK;

    // Output monitor: every handshake must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (!RST && SYM_VALID && SYM_READY) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fails++;
                $display("FAIL sym_unexpected got %0d expected none", SYM_OUT);
            end else begin
                logic [3:0] exp_sym;
                exp_sym = sb.pop_front();
                if (SYM_OUT !== exp_sym) begin
                    n_fails++;
                    $display("FAIL sym_out got %0d expected %0d", SYM_OUT, exp_sym);
                end
            end
        end
        if (!RST && ERR === 1'b1) err_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic load(input logic [3:0] addr, input logic [3:0] len, input logic [MAX_LEN-1:0] code);
        TBL_WE   = 1'b1;
        TBL_ADDR = addr;
        TBL_LEN  = len;
        TBL_CODE = code;
        tick();
        TBL_WE   = 1'b0;
        #1;
    endtask

    // Offers one bit and returns just after the edge that accepted it.
    task automatic send_bit(input logic b);
        int guard = 0;
        BIT_IN    = b;
        BIT_VALID = 1'b1;
        #1;
        while (!BIT_READY && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_fails++;
            $display("FAIL bit_ready_timeout got 0 expected 1");
        end
        tick();
        BIT_VALID = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        expect_val(name, sb.size(), 0);
    endtask

    task automatic load_basic();
        load(4'd0, 4'd1, 8'b0);
        load(4'd1, 4'd2, 8'b10);
        load(4'd2, 4'd3, 8'b110);
        load(4'd3, 4'd3, 8'b111);
    endtask

    task automatic test_reset();
        do_reset();
        expect_val("rst_bit_ready", BIT_READY, 1);
        expect_val("rst_sym_valid", SYM_VALID, 0);
        expect_val("rst_sym_out", SYM_OUT, 0);
        expect_val("rst_err", ERR, 0);
        expect_val("rst_sym_count", SYM_COUNT, 0);
        expect_val("rst_err_count", ERR_COUNT, 0);
    endtask

    task automatic test_stream();
        logic [8:0] bits = 9'b010110111;
        int e0 = err_seen;
        load_basic();
        SYM_READY = 1'b1;
        sb.push_back(4'd0);
        sb.push_back(4'd1);
        sb.push_back(4'd2);
        sb.push_back(4'd3);
        send_bit(bits[8]);
        expect_val("stream_latency_valid", SYM_VALID, 1);
        expect_val("stream_latency_sym", SYM_OUT, 0);
        expect_val("stream_ready_gap", BIT_READY, 0);
        for (int i = 7; i >= 0; i--) send_bit(bits[i]);
        wait_drain("stream_drain");
        tick();
        expect_val("stream_sym_count", SYM_COUNT, 4);
        expect_val("stream_no_err", err_seen - e0, 0);
    endtask

    task automatic test_backpressure();
        SYM_READY = 1'b0;
        sb.push_back(4'd0);
        send_bit(1'b0);
        BIT_IN    = 1'b1;
        BIT_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_val("hold_valid", SYM_VALID, 1);
            expect_val("hold_sym", SYM_OUT, 0);
            expect_val("hold_bit_ready", BIT_READY, 0);
        end
        SYM_READY = 1'b1;
        sb.push_back(4'd1);
        send_bit(1'b1);
        send_bit(1'b0);
        wait_drain("hold_drain");
        expect_val("hold_sym_count", SYM_COUNT, 6);
    endtask

    task automatic test_back_to_back();
        logic [CNT_W-1:0] c0 = SYM_COUNT;
        for (int i = 0; i < 4; i++) sb.push_back(4'd0);
        BIT_IN    = 1'b0;
        BIT_VALID = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        BIT_VALID = 1'b0;
        expect_val("b2b_count", SYM_COUNT - c0, 4);
        wait_drain("b2b_drain");
    endtask

    task automatic test_error();
        int e0;
        do_reset();
        load(4'd5, 4'd8, 8'hFF);
        SYM_READY = 1'b1;
        e0 = err_seen;
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        expect_val("err_early", ERR, 0);
        send_bit(1'b0);
        expect_val("err_pulse", ERR, 1);
        expect_val("err_count", ERR_COUNT, 1);
        expect_val("err_no_valid", SYM_VALID, 0);
        tick();
        expect_val("err_one_cycle", ERR, 0);
        expect_val("err_seen", err_seen - e0, 1);
        sb.push_back(4'd5);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        expect_val("err_long_valid", SYM_VALID, 1);
        wait_drain("err_drain");
        expect_val("err_long_count", SYM_COUNT, 1);
        expect_val("err_count_after", ERR_COUNT, 1);
    endtask

    task automatic test_duplicate();
        do_reset();
        load(4'd2, 4'd9, 8'h00);
        load(4'd4, 4'd2, 8'hF1);
        load(4'd9, 4'd2, 8'h01);
        sb.push_back(4'd4);
        send_bit(1'b0);
        send_bit(1'b1);
        wait_drain("dup_drain");
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        expect_val("dup_len9_unused_err", ERR, 1);
        expect_val("dup_err_count", ERR_COUNT, 1);
    endtask

    task automatic test_reset_midcode();
        do_reset();
        load_basic();
        sb.push_back(4'd0);
        send_bit(1'b0);
        wait_drain("mid_pre_drain");
        expect_val("mid_pre_count", SYM_COUNT, 1);
        send_bit(1'b1);
        send_bit(1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1;
        expect_val("mid_rst_count", SYM_COUNT, 0);
        expect_val("mid_rst_ready", BIT_READY, 1);
        send_bit(1'b0);
        tick();
        expect_val("mid_empty_no_decode", SYM_VALID, 0);
        load(4'd0, 4'd1, 8'b0);
        sb.push_back(4'd0);
        send_bit(1'b0);
        wait_drain("mid_drain");
        expect_val("mid_post_count", SYM_COUNT, 1);
    endtask

    task automatic test_flush();
        load(4'd1, 4'd2, 8'b10);
        load(4'd2, 4'd3, 8'b110);
        load(4'd3, 4'd3, 8'b111);
        send_bit(1'b1);
        send_bit(1'b1);
        load(4'd7, 4'd1, 8'b1);
        sb.push_back(4'd7);
        send_bit(1'b1);
        expect_val("flush_sym", SYM_OUT, 7);
        wait_drain("flush_drain");
        expect_val("flush_count", SYM_COUNT, 2);
    endtask

    initial begin
        RST       = 1'b1;
        TBL_WE    = 1'b0;
        TBL_ADDR  = '0;
        TBL_LEN   = '0;
        TBL_CODE  = '0;
        BIT_IN    = 1'b0;
        BIT_VALID = 1'b0;
        SYM_READY = 1'b1;

        test_reset();
        test_stream();
        test_backpressure();
        test_back_to_back();
        test_error();
        test_duplicate();
        test_reset_midcode();
        test_flush();

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Serial Huffman bitstream decoder that recovers 4-bit symbols from the code bits produced by the Huffman coding stage. It sits directly downstream of the coder: it accepts one code bit per cycle, matches the accumulated prefix against a 16-entry run-time-loaded code table, and presents each decoded symbol on a valid/ready output. The 4-bit symbol can drive the 4-bit LED output directly.

## Interface
- MAX_LEN, 8: maximum code length in bits (1..8); the accumulator is MAX_LEN wide.
- CNT_W, 16: width of the decoded-symbol counter.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- TBL_WE  in  1  table write strobe.
- TBL_ADDR  in  4  symbol index being written.
- TBL_LEN  in  4  code length; 0 = entry unused, 1..MAX_LEN valid, >MAX_LEN treated as 0.
- TBL_CODE  in  MAX_LEN  code bits, right-aligned, MSB-first transmission order.
- BIT_IN  in  1  code bit.
- BIT_VALID  in  1  BIT_IN is valid.
- BIT_READY  out  1  decoder accepts a bit this cycle.
- SYM_OUT  out  4  decoded symbol.
- SYM_VALID  out  1  SYM_OUT holds an unconsumed symbol.
- SYM_READY  in  1  downstream consumes SYM_OUT.
- ERR  out  1  one-cycle pulse: no match after MAX_LEN bits.
- SYM_COUNT  out  CNT_W  symbols decoded since reset, saturating.
- ERR_COUNT  out  8  errors since reset, saturating.

## Operation
- State: accumulator acc[MAX_LEN-1:0], bit count n (0..MAX_LEN-1), output hold register, table len[16] and code[16].
- The bit is accepted when BIT_VALID & BIT_READY.
- BIT_READY = ~SYM_VALID & ~TBL_WE. This is a combinational output.
- On accept, the candidate is c = {acc, BIT_IN} over the low n+1 bits, with length L = n+1.
- Entry i matches when len[i] == L and code[i][L-1:0] == c. Upper code bits are ignored.
- Multiple matches: the lowest index wins.
- On a match:
  - SYM_OUT <= i and SYM_VALID <= 1.
  - acc and n are cleared.
  - SYM_COUNT increments, saturating at all-ones.
- No match and L < MAX_LEN: acc <= c and n <= L.
- No match and L == MAX_LEN:
  - ERR pulses for one cycle.
  - acc and n are cleared.
  - ERR_COUNT increments, saturating at 255.
  - SYM_VALID is unaffected.
- Output: SYM_VALID & SYM_READY clears SYM_VALID. No new bit is accepted in that same cycle because BIT_READY was low, so there is no overlap.
- Table write: when TBL_WE is high, len/code[TBL_ADDR] is updated at the clock edge, and acc and n are flushed (a partial code is discarded). SYM_VALID and SYM_OUT are untouched.
- Reset:
  - All len entries = 0 (table empty) and code entries = 0.
  - acc = 0, n = 0.
  - SYM_VALID = 0, SYM_OUT = 0, ERR = 0.
  - SYM_COUNT = 0, ERR_COUNT = 0.
  - BIT_READY therefore reads 1 after reset when TBL_WE is low.
- Empty table: every MAX_LEN-bit group produces ERR.

## Timing
- Latency: the symbol is visible (SYM_VALID = 1) the cycle after its final bit is accepted.
- ERR is asserted the cycle after the MAX_LEN-th unmatched bit and lasts exactly one cycle.
- Throughput:
  - With SYM_READY tied high, BIT_READY is low for the one cycle after each decode. A 1-bit code therefore sustains one symbol per 2 cycles.
  - Longer codes run at one bit per cycle until the final bit.
- SYM_OUT and SYM_VALID stay stable while SYM_VALID = 1 and SYM_READY = 0.
- Reset mid-code: the partial prefix is lost, and the first bit accepted after reset starts a new code.
- RST has priority over TBL_WE and bit acceptance.
- TBL_WE in the same cycle as BIT_VALID: the bit is not accepted because BIT_READY is low, and the source holds it.

## Test plan
- Load table 0="0" (L1), 1="10" (L2), 2="110" (L3), 3="111" (L3) with SYM_READY = 1. Stream bits 0,1,0,1,1,0,1,1,1 → SYM_OUT 0,1,2,3 in order, SYM_COUNT = 4, ERR never asserted.
- Same table with SYM_READY = 0 for 5 cycles after the first symbol → SYM_VALID held with SYM_OUT = 0 and BIT_READY = 0. The next symbol (1) appears only after SYM_READY is raised.
- Table containing only code 0xFF (L8) for symbol 5. Stream eight 0 bits → ERR one-cycle pulse on the 9th cycle, ERR_COUNT = 1, no SYM_VALID. Then eight 1s → SYM_OUT = 5.
- Duplicate entries 4 and 9 both set to "01" (L2). Stream 0,1 → SYM_OUT = 4.
- After two bits "11" of a 3-bit code, assert RST for one cycle, then stream 0 → SYM_OUT = 0. SYM_COUNT resets to 0 and then reads 1; all table entries read back as empty (no decode until reloaded; the 0 decodes only after reloading entry 0).
- After bits "11", write entry 7 = "1" (L1) → flush. The next bit 1 decodes as SYM_OUT = 7, not as a continuation of the earlier prefix.
